hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//  - Sequences MULT/DIV(U-less) issue and writeback for the multicycle CPU.
//  - Latches rs/rt operands and pulses a go strobe to the multiplier or divider.
//  - Waits for the unit's done, then captures its hi/lo result into architectural HI/LO.
//  - Serves HI/LO to the datapath (mfhi/mflo), and takes direct writes (mthi/mtlo).
//  - Stalls the control unit via busy.
// PARAMETERS
//  - WIDTH     32  data width of operands, HI, LO
//  - MAX_WAIT  40  WAIT cycles allowed before timeout_err
// PORTS
//  - clk           in   1      system clock; all state changes on rising edge
//  - reset         in   1      synchronous, active-high reset
//  - mult_start    in   1      request MULT of rs_val*rt_val (sampled in IDLE only)
//  - div_start     in   1      request DIV rs_val/rt_val (sampled in IDLE only)
//  - mthi          in   1      write rs_val to HI (IDLE only)
//  - mtlo          in   1      write rs_val to LO (IDLE only)
//  - rs_val        in   WIDTH  operand A / mthi-mtlo data
//  - rt_val        in   WIDTH  operand B
//  - md_op_a       out  WIDTH  latched operand A to units; reset 0
//  - md_op_b       out  WIDTH  latched operand B to units; reset 0
//  - mult_go       out  1      1-cycle start pulse to multiplier; reset 0
//  - div_go        out  1      1-cycle start pulse to divider; reset 0
//  - mult_done     in   1      multiplier result valid
//  - mult_hi       in   WIDTH  multiplier product, upper half
//  - mult_lo       in   WIDTH  multiplier product, lower half
//  - div_done      in   1      divider result valid
//  - div_hi        in   WIDTH  remainder
//  - div_lo        in   WIDTH  quotient
//  - hi            out  WIDTH  architectural HI; reset 0
//  - lo            out  WIDTH  architectural LO; reset 0
//  - busy          out  1      high in GO/WAIT; reset 0
//  - div_zero      out  1      1-cycle pulse: DIV with rt_val==0; reset 0
//  - timeout_err   out  1      1-cycle pulse: unit never answered; reset 0
// BEHAVIOUR
//  - FSM states:
//    - IDLE: accepts mult_start/div_start; latches md_op_a<=rs_val, md_op_b<=rt_val and op; ->GO.
//    - GO: mult_go or div_go =1 for exactly this cycle; ->WAIT.
//    - WAIT: samples only the done of the issued unit.
//      - On done: hi/lo <= unit hi/lo at that edge; ->IDLE.
//      - On MAX_WAIT cycles elapsed without done: timeout_err pulses for 1 cycle; HI/LO unchanged; ->IDLE.
//  - Latency: start sampled at edge k -> go high in cycle k+1 -> HI/LO written at the edge where done=1.
//    - busy is combinational from state; it deasserts the cycle after capture.
//  - Start arbitration:
//    - mult_start and div_start together: MULT wins; div_start is dropped.
//    - Starts while busy are ignored; control must stall on busy.
//  - DIV by zero: div_start with rt_val==0 in IDLE.
//    - No issue; state stays IDLE; div_zero=1 the next cycle; HI/LO unchanged.
//  - mthi/mtlo (IDLE only):
//    - HI/LO <= rs_val at the next edge; both may fire together.
//    - Ignored when busy or when a start is accepted the same cycle (start has priority).
//  - done in IDLE or GO: ignored. done of the non-issued unit: ignored.
//  - Operand latches hold until the next accepted start.
//  - Reset mid-operation:
//    - Immediately returns to IDLE; clears HI, LO, operands and go pulses.
//    - A done arriving after reset is ignored.
//  - Wait counter: cleared on entering WAIT; saturates; width $clog2(MAX_WAIT+1).
// STRUCTURE
//  - muldiv_pkg: state encoding (IDLE, GO, WAIT), op encoding (OP_MULT, OP_DIV), default MAX_WAIT.
//  - Sub-module wait_timer: clear/enable counter with expired flag.
//  - Everything else stays in hilo_ctrl.
// TESTING
//  - MULT: rs=7, rt=-3, stub done after 33 cycles with hi=FFFFFFFF lo=FFFFFFEB.
//    -> mult_go 1 cycle; busy for 34 cycles; hi/lo hold the stub values.
//  - DIV: rs=100, rt=7, stub hi=2 lo=14.
//    -> div_go pulse; hi=2, lo=14 after done.
//  - DIV: rs=5, rt=0.
//    -> no div_go; div_zero pulse next cycle; busy stays 0; hi/lo unchanged.
//  - mult_start and div_start same cycle.
//    -> only mult_go; a div_done injected in WAIT is ignored.
//  - mthi rs=0xA5A5A5A5 then mtlo rs=0x1; mthi during busy.
//    -> hi=A5A5A5A5, lo=1; the busy-time write is dropped.
//  - No done for MAX_WAIT cycles.
//    -> timeout_err pulse; back to IDLE.
//  - Reset in WAIT, then late done.
//    -> hi=lo=0; state IDLE; done ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GO,
    WAIT
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

  localparam int DEFAULT_MAX_WAIT = 40;

endpackage

// File: rtl/wait_timer.sv
// Saturating cycle counter; expired marks the LIMIT-th enabled cycle since clear.
module wait_timer #(
  parameter int LIMIT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] TOP  = CW'(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  // Count holds the number of completed enabled cycles, so the current one is the LIMIT-th at LAST.
  assign expired = (count >= LAST);

endmodule

// File: rtl/hilo_ctrl.sv
// Issues MULT/DIV to external units, captures their results into HI/LO, serves mthi/mtlo.
module hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] md_op_a,
  output logic [WIDTH-1:0] md_op_b,
  output logic             mult_go,
  output logic             div_go,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_zero,
  output logic             timeout_err
);

  state_t state;
  op_t    op;
  logic   expired;
  logic   accept;
  logic   div_by_zero;
  logic   unit_done;

  wait_timer #(.LIMIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == GO),
    .en      (state == WAIT),
    .expired (expired)
  );

  always_comb begin
    accept      = 1'b0;
    div_by_zero = 1'b0;
    unit_done   = 1'b0;
    // MULT wins a simultaneous request; a zero divisor is rejected without issue.
    accept      = mult_start || (div_start && (rt_val != '0));
    div_by_zero = div_start && !mult_start && (rt_val == '0);
    unit_done   = (op == OP_MULT) ? mult_done : div_done;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_MULT;
      md_op_a     <= '0;
      md_op_b     <= '0;
      mult_go     <= 1'b0;
      div_go      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mult_go     <= 1'b0;
      div_go      <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op      <= mult_start ? OP_MULT : OP_DIV;
            md_op_a <= rs_val;
            md_op_b <= rt_val;
            mult_go <= mult_start;
            div_go  <= !mult_start;
            state   <= GO;
          end else begin
            div_zero <= div_by_zero;
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        GO: state <= WAIT;
        WAIT: begin
          if (unit_done) begin
            hi    <= (op == OP_MULT) ? mult_hi : div_hi;
            lo    <= (op == OP_MULT) ? mult_lo : div_lo;
            state <= IDLE;
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios with literal expectations plus a randomized run vs. a cycle model.
module tb_hilo_ctrl;

  localparam int W  = 32;
  localparam int MW = 40;

  logic         clk = 1'b0;
  logic         reset, mult_start, div_start, mthi, mtlo;
  logic [W-1:0] rs_val, rt_val;
  logic [W-1:0] md_op_a, md_op_b;
  logic         mult_go, div_go;
  logic         mult_done, div_done;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [W-1:0] hi, lo;
  logic         busy, div_zero, timeout_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase -1 idle, 0 go cycle, n>=1 means the n-th waiting cycle.
  logic [W-1:0] m_hi, m_lo, m_a, m_b;
  int           m_phase;
  bit           m_is_mult;
  bit           m_mult_go, m_div_go, m_div_zero, m_timeout;

  hilo_ctrl #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .mthi(mthi), .mtlo(mtlo), .rs_val(rs_val), .rt_val(rt_val),
    .md_op_a(md_op_a), .md_op_b(md_op_b), .mult_go(mult_go), .div_go(div_go),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    m_mult_go  = 1'b0;
    m_div_go   = 1'b0;
    m_div_zero = 1'b0;
    m_timeout  = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_phase = -1;
    end else if (m_phase < 0) begin
      if (mult_start || (div_start && rt_val != 0)) begin
        m_is_mult = mult_start;
        m_a = rs_val;
        m_b = rt_val;
        m_phase = 0;
        if (mult_start) m_mult_go = 1'b1;
        else            m_div_go  = 1'b1;
      end else begin
        if (div_start) m_div_zero = 1'b1;
        if (mthi) m_hi = rs_val;
        if (mtlo) m_lo = rs_val;
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_is_mult ? mult_done : div_done) begin
      m_hi = m_is_mult ? mult_hi : div_hi;
      m_lo = m_is_mult ? mult_lo : div_lo;
      m_phase = -1;
    end else if (m_phase >= MW) begin
      m_timeout = 1'b1;
      m_phase = -1;
    end else begin
      m_phase++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_inputs();
    mult_start = 0; div_start = 0; mthi = 0; mtlo = 0;
    mult_done = 0; div_done = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("md_op_a", md_op_a, m_a);
      chk("md_op_b", md_op_b, m_b);
      chk("mult_go", {31'd0, mult_go}, {31'd0, m_mult_go});
      chk("div_go", {31'd0, div_go}, {31'd0, m_div_go});
      chk("busy", {31'd0, busy}, {31'd0, m_phase >= 0});
      chk("div_zero", {31'd0, div_zero}, {31'd0, m_div_zero});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_timeout});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt, go_cnt, to_cnt, to_at;
    idle_inputs();
    reset = 1; rs_val = 0; rt_val = 0;
    mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;
    m_phase = -1; m_is_mult = 1'b1;
    step(); step();
    chk_en = 1'b1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_op_a", md_op_a, 32'd0);
    reset = 0;
    step();

    // MULT 7 * -3, stub answers in the 33rd waiting cycle.
    rs_val = 32'd7; rt_val = 32'hFFFF_FFFD; mult_start = 1;
    step();
    mult_start = 0;
    busy_cnt = 0; go_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (busy) busy_cnt++;
      if (mult_go) go_cnt++;
      mult_done = (c == 33);
      mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFEB;
      step();
    end
    mult_done = 0;
    chk("mult_busy_cycles", busy_cnt, 32'd34);
    chk("mult_go_pulses", go_cnt, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    chk("mult_op_b", md_op_b, 32'hFFFF_FFFD);

    // DIV 100 / 7.
    rs_val = 32'd100; rt_val = 32'd7; div_start = 1;
    step();
    div_start = 0;
    go_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (div_go) go_cnt++;
      div_done = (c == 5); div_hi = 32'd2; div_lo = 32'd14;
      step();
    end
    div_done = 0;
    chk("div_go_pulses", go_cnt, 32'd1);
    chk("div_hi", hi, 32'd2);
    chk("div_lo", lo, 32'd14);

    // DIV by zero.
    rs_val = 32'd5; rt_val = 32'd0; div_start = 1;
    step();
    div_start = 0;
    chk("dz_pulse", {31'd0, div_zero}, 32'd1);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_no_go", {31'd0, div_go}, 32'd0);
    chk("dz_hi", hi, 32'd2);
    step();
    chk("dz_pulse_end", {31'd0, div_zero}, 32'd0);
    chk("dz_lo", lo, 32'd14);

    // Simultaneous starts: MULT wins, divider done ignored.
    rs_val = 32'd3; rt_val = 32'd4; mult_start = 1; div_start = 1;
    step();
    mult_start = 0; div_start = 0;
    chk("both_mult_go", {31'd0, mult_go}, 32'd1);
    chk("both_div_go", {31'd0, div_go}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      div_done  = (c == 2); div_hi = 32'hDEAD_BEEF; div_lo = 32'hDEAD_BEEF;
      mult_done = (c == 5); mult_hi = 32'd0; mult_lo = 32'd12;
      step();
    end
    idle_inputs();
    chk("both_hi", hi, 32'd0);
    chk("both_lo", lo, 32'd12);

    // mthi / mtlo, then a dropped mthi while busy.
    rs_val = 32'hA5A5_A5A5; mthi = 1;
    step();
    mthi = 0; mtlo = 1; rs_val = 32'd1;
    step();
    mtlo = 0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mtlo_lo", lo, 32'd1);
    rs_val = 32'd2; rt_val = 32'd3; mult_start = 1;
    step();
    mult_start = 0; mthi = 1; rs_val = 32'hFFFF_0000;
    step();
    mthi = 0;
    for (int c = 0; c < 6; c++) begin
      mult_done = (c == 3); mult_hi = 32'd0; mult_lo = 32'd6;
      step();
    end
    mult_done = 0;
    chk("busy_mthi_dropped", hi, 32'd0);
    chk("busy_mult_lo", lo, 32'd6);

    // Timeout: no answer at all.
    rs_val = 32'd9; rt_val = 32'd9; mult_start = 1;
    step();
    mult_start = 0;
    to_cnt = 0; to_at = -1;
    for (int c = 0; c < 60; c++) begin
      if (timeout_err) begin to_cnt++; to_at = c; end
      step();
    end
    chk("timeout_pulses", to_cnt, 32'd1);
    chk("timeout_cycle", to_at, 32'd41);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_lo_kept", lo, 32'd6);

    // Reset while waiting, then a late done.
    rs_val = 32'd11; rt_val = 32'd13; mult_start = 1;
    step();
    mult_start = 0;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    mult_done = 1; mult_hi = 32'h1234_5678; mult_lo = 32'h9ABC_DEF0;
    step(); step();
    mult_done = 0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_a", md_op_a, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(199) == 0);
      mult_start = ($urandom_range(7) == 0);
      div_start  = ($urandom_range(7) == 0);
      rs_val     = $urandom;
      rt_val     = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      mthi       = ($urandom_range(5) == 0);
      mtlo       = ($urandom_range(5) == 0);
      if (div_start && !mult_start && rt_val == 0) begin
        mthi = 0; mtlo = 0;
      end
      mult_done  = ($urandom_range(11) == 0);
      div_done   = ($urandom_range(11) == 0);
      mult_hi = $urandom; mult_lo = $urandom;
      div_hi  = $urandom; div_lo  = $urandom;
      step();
    end
    idle_inputs();
    reset = 0;
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
